// File: rtl/bus_rr_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM encoding and
// default bus widths.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int BUS_AW = 8;
  localparam int BUS_DW = 8;
  localparam int GNT_W  = 3;

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Requester handshake plus memory-bus signals of the arbiter. The arbiter
// uses the slave view; requesters and the memory model use the master view.
interface bus_rr_arbiter_if
  import bus_pkg::*;
#(
  parameter int N  = 2,
  parameter int AW = BUS_AW,
  parameter int DW = BUS_DW
);
  logic [N-1:0]     req;
  logic [N-1:0]     req_wr;
  logic [N*AW-1:0]  req_addr;
  logic [N*DW-1:0]  req_wdata;
  logic [N-1:0]     ack;
  logic [DW-1:0]    rdata;
  logic [GNT_W-1:0] gnt_id;
  logic             busy;
  logic             ce;
  logic             rd;
  logic             wr;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    data_wr;
  logic [DW-1:0]    data_rd;

  modport slave (
    input  req, req_wr, req_addr, req_wdata, data_rd,
    output ack, rdata, gnt_id, busy, ce, rd, wr, addr, data_wr
  );

  modport master (
    output req, req_wr, req_addr, req_wdata, data_rd,
    input  ack, rdata, gnt_id, busy, ce, rd, wr, addr, data_wr
  );
endinterface

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after the
// pointer, wrapping modulo N.
module rr_pick
  import bus_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [GNT_W-1:0] i_ptr,
  output logic [GNT_W-1:0] o_winner,
  output logic             o_any
);

  always_comb begin
    int w_dist;
    int w_best;
    o_winner = '0;
    o_any    = |i_req;
    w_best   = N;
    w_dist   = 0;
    // Rotated distance from the pointer; the smallest distance wins.
    for (int i = 0; i < N; i++) begin
      w_dist = (i + N - int'(i_ptr)) % N;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_winner = GNT_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one registered memory bus between N requesters;
// each transaction runs IDLE -> ACCESS (WAIT_CYC+1 cycles) -> RESP.
//
//   state     | meaning
//   ST_IDLE   | bus free; pick a winner and launch its strobes
//   ST_ACCESS | ce + rd/wr held while the wait counter runs down to 0
//   ST_RESP   | strobes dropped; ack pulses on the edge leaving this state
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int N        = 2,
  parameter int AW       = BUS_AW,
  parameter int DW       = BUS_DW,
  parameter int WAIT_CYC = 0
) (
  input logic            clk,
  input logic            rst_n,
  bus_rr_arbiter_if.slave io_bus
);

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_cnt;
  logic [N-1:0]     r_ack;
  logic [DW-1:0]    r_rdata;
  logic [DW-1:0]    r_data_wr;
  logic [AW-1:0]    r_addr;
  logic [GNT_W-1:0] r_gnt_id;
  logic [GNT_W-1:0] r_rr_ptr;
  logic             r_busy;
  logic             r_ce;
  logic             r_rd;
  logic             r_wr;

  logic [N-1:0]     w_req_eff;
  logic [GNT_W-1:0] w_winner;
  logic [GNT_W-1:0] w_ptr_next;
  logic             w_any;
  logic             w_sel_wr;
  logic [AW-1:0]    w_sel_addr;
  logic [DW-1:0]    w_sel_wdata;
  logic [N-1:0]     w_gnt_onehot;

  // The requester being acked still holds req this cycle; that is not a new request.
  assign w_req_eff = io_bus.req & ~r_ack;

  rr_pick #(.N(N)) u_pick (
    .i_req    (w_req_eff),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_ptr_next = (w_winner == GNT_W'(N - 1)) ? '0 : w_winner + 1'b1;

  always_comb begin
    w_sel_wr     = 1'b0;
    w_sel_addr   = '0;
    w_sel_wdata  = '0;
    w_gnt_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (w_winner == GNT_W'(i)) begin
        w_sel_wr    = io_bus.req_wr[i];
        w_sel_addr  = io_bus.req_addr[i*AW +: AW];
        w_sel_wdata = io_bus.req_wdata[i*DW +: DW];
      end
      w_gnt_onehot[i] = (r_gnt_id == GNT_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_any) w_next = ST_ACCESS;
      ST_ACCESS: if (r_cnt == '0) w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_ack     <= '0;
      r_rdata   <= '0;
      r_data_wr <= '0;
      r_addr    <= '0;
      r_gnt_id  <= '0;
      r_rr_ptr  <= '0;
      r_busy    <= 1'b0;
      r_ce      <= 1'b0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_ce     <= 1'b1;
            r_busy   <= 1'b1;
            r_rd     <= ~w_sel_wr;
            r_wr     <= w_sel_wr;
            r_addr   <= w_sel_addr;
            r_gnt_id <= w_winner;
            r_cnt    <= 4'(WAIT_CYC);
            r_rr_ptr <= w_ptr_next;
            if (w_sel_wr) r_data_wr <= w_sel_wdata;
          end
        end
        ST_ACCESS: begin
          if (r_cnt == '0) begin
            r_ce   <= 1'b0;
            r_rd   <= 1'b0;
            r_wr   <= 1'b0;
            r_addr <= '0;
            if (r_rd) r_rdata <= io_bus.data_rd;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          r_busy <= 1'b0;
          r_ack  <= w_gnt_onehot;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.ack     = r_ack;
  assign io_bus.rdata   = r_rdata;
  assign io_bus.gnt_id  = r_gnt_id;
  assign io_bus.busy    = r_busy;
  assign io_bus.ce      = r_ce;
  assign io_bus.rd      = r_rd;
  assign io_bus.wr      = r_wr;
  assign io_bus.addr    = r_addr;
  assign io_bus.data_wr = r_data_wr;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: one instance with no wait states and
// one with WAIT_CYC=3, sharing a single memory model.
module tb_bus_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_rr_arbiter_if #(.N(2), .AW(8), .DW(8)) bi0 ();
  bus_rr_arbiter_if #(.N(2), .AW(8), .DW(8)) bi1 ();

  bus_rr_arbiter #(.N(2), .AW(8), .DW(8), .WAIT_CYC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .io_bus(bi0)
  );
  bus_rr_arbiter #(.N(2), .AW(8), .DW(8), .WAIT_CYC(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .io_bus(bi1)
  );

  logic [7:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (bi0.ce && bi0.wr) mem[bi0.addr] <= bi0.data_wr;
    if (bi1.ce && bi1.wr) mem[bi1.addr] <= bi1.data_wr;
  end
  assign bi0.data_rd = mem[bi0.addr];
  assign bi1.data_rd = mem[bi1.addr];

  typedef struct {
    logic [1:0] ack;
    logic [7:0] rdata;
    logic [2:0] gnt;
    logic       busy, ce, rd, wr;
    logic [7:0] addr, data_wr;
  } snap_t;

  typedef struct {
    int         id;
    logic       wr;
    logic [7:0] addr, wdata, rdata;
  } exp_t;

  typedef struct {
    int         sel;
    int         id;
    logic       wr;
    logic [7:0] addr, wdata, rdata;
    int         lat, ce_cyc;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=missing required=present", nm);
  endtask

  function automatic snap_t snap(input int sel);
    snap_t s;
    if (sel == 0) begin
      s.ack = bi0.ack; s.rdata = bi0.rdata; s.gnt = bi0.gnt_id; s.busy = bi0.busy;
      s.ce = bi0.ce; s.rd = bi0.rd; s.wr = bi0.wr; s.addr = bi0.addr; s.data_wr = bi0.data_wr;
    end else begin
      s.ack = bi1.ack; s.rdata = bi1.rdata; s.gnt = bi1.gnt_id; s.busy = bi1.busy;
      s.ce = bi1.ce; s.rd = bi1.rd; s.wr = bi1.wr; s.addr = bi1.addr; s.data_wr = bi1.data_wr;
    end
    return s;
  endfunction

  task automatic set_req(input int sel, input int id, input logic v, input logic wr,
                         input logic [7:0] a, input logic [7:0] d);
    if (sel == 0) begin
      bi0.req[id] = v; bi0.req_wr[id] = wr; bi0.req_addr[id*8 +: 8] = a; bi0.req_wdata[id*8 +: 8] = d;
    end else begin
      bi1.req[id] = v; bi1.req_wr[id] = wr; bi1.req_addr[id*8 +: 8] = a; bi1.req_wdata[id*8 +: 8] = d;
    end
  endtask

  task automatic push(input int id, input logic wr, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] r);
    exp_t e;
    e.id = id; e.wr = wr; e.addr = a; e.wdata = d; e.rdata = r;
    sb.push_back(e);
  endtask

  // Checks bus launch against the scoreboard head and pops it on each ack.
  task automatic observe(input int sel, input int n_acks, output int lat, output int ce_cyc);
    snap_t      s;
    exp_t       e;
    logic       prev_ce;
    logic [1:0] exp_ack;
    int         seen, cyc;
    s = snap(sel);
    prev_ce = s.ce;
    seen = 0; cyc = 0; lat = -1; ce_cyc = 0;
    while (seen < n_acks && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      s = snap(sel);
      if (s.ce) ce_cyc++;
      if (s.ce && !prev_ce) begin
        if (sb.size() == 0) fail("sb_entry_at_ce");
        else begin
          e = sb[0];
          chk("gnt_id", 32'(s.gnt), 32'(e.id));
          chk("addr", 32'(s.addr), 32'(e.addr));
          chk("rd", 32'(s.rd), 32'(!e.wr));
          chk("wr", 32'(s.wr), 32'(e.wr));
          chk("busy", 32'(s.busy), 32'd1);
          if (e.wr) chk("data_wr", 32'(s.data_wr), 32'(e.wdata));
        end
      end
      prev_ce = s.ce;
      if (s.ack != 2'b00) begin
        if (sb.size() == 0) fail("sb_entry_at_ack");
        else begin
          e = sb.pop_front();
          exp_ack = 2'b00;
          exp_ack[e.id] = 1'b1;
          chk("ack", 32'(s.ack), 32'(exp_ack));
          chk("rdata", 32'(s.rdata), 32'(e.rdata));
        end
        if (seen == 0) lat = cyc - 1;
        seen++;
      end
    end
    if (seen < n_acks) fail("ack_timeout");
  endtask

  vec_t vecs[11];

  initial begin
    int    lat, ce_cyc;
    snap_t s;
    logic  got;

    vecs[0]  = '{0, 0, 1'b1, 8'h11, 8'hAA, 8'h00, 2, 1};
    vecs[1]  = '{0, 0, 1'b0, 8'h11, 8'h00, 8'hAA, 2, 1};
    vecs[2]  = '{0, 1, 1'b1, 8'h20, 8'h5C, 8'hAA, 2, 1};
    vecs[3]  = '{0, 1, 1'b0, 8'h20, 8'h00, 8'h5C, 2, 1};
    vecs[4]  = '{0, 0, 1'b0, 8'h13, 8'h00, 8'h0A, 2, 1};
    vecs[5]  = '{0, 1, 1'b1, 8'h11, 8'h33, 8'h0A, 2, 1};
    vecs[6]  = '{0, 0, 1'b0, 8'h11, 8'h00, 8'h33, 2, 1};
    vecs[7]  = '{1, 0, 1'b0, 8'h12, 8'h00, 8'hAB, 5, 4};
    vecs[8]  = '{1, 1, 1'b1, 8'h14, 8'h77, 8'hAB, 5, 4};
    vecs[9]  = '{1, 1, 1'b0, 8'h14, 8'h00, 8'h77, 5, 4};
    vecs[10] = '{0, 1, 1'b0, 8'h12, 8'h00, 8'hAB, 2, 1};

    bi0.req = '0; bi0.req_wr = '0; bi0.req_addr = '0; bi0.req_wdata = '0;
    bi1.req = '0; bi1.req_wr = '0; bi1.req_addr = '0; bi1.req_wdata = '0;

    // Reset held with both requesters pending: everything quiet.
    set_req(0, 0, 1'b1, 1'b1, 8'h12, 8'hAB);
    set_req(0, 1, 1'b1, 1'b1, 8'h13, 8'h0A);
    repeat (3) @(posedge clk);
    #1;
    s = snap(0);
    chk("rst_ack", 32'(s.ack), 0);
    chk("rst_rdata", 32'(s.rdata), 0);
    chk("rst_gnt", 32'(s.gnt), 0);
    chk("rst_busy", 32'(s.busy), 0);
    chk("rst_ce", 32'(s.ce), 0);
    chk("rst_rd", 32'(s.rd), 0);
    chk("rst_wr", 32'(s.wr), 0);
    chk("rst_addr", 32'(s.addr), 0);
    chk("rst_data_wr", 32'(s.data_wr), 0);

    // Contention straight out of reset: grants 0,1,0,1.
    push(0, 1'b1, 8'h12, 8'hAB, 8'h00);
    push(1, 1'b1, 8'h13, 8'h0A, 8'h00);
    push(0, 1'b1, 8'h12, 8'hAB, 8'h00);
    push(1, 1'b1, 8'h13, 8'h0A, 8'h00);
    rst_n = 1'b1;
    observe(0, 4, lat, ce_cyc);
    bi0.req = '0;

    for (int v = 0; v < 11; v++) begin
      @(posedge clk); #1;
      push(vecs[v].id, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].rdata);
      set_req(vecs[v].sel, vecs[v].id, 1'b1, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      observe(vecs[v].sel, 1, lat, ce_cyc);
      set_req(vecs[v].sel, vecs[v].id, 1'b0, 1'b0, 8'h00, 8'h00);
      chk($sformatf("latency_v%0d", v), 32'(lat), 32'(vecs[v].lat));
      chk($sformatf("ce_cycles_v%0d", v), 32'(ce_cyc), 32'(vecs[v].ce_cyc));
    end

    // Asynchronous reset while a read is in ACCESS.
    @(posedge clk); #1;
    set_req(0, 0, 1'b1, 1'b0, 8'h11, 8'h00);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge clk); #1;
      s = snap(0);
      if (s.ce) got = 1'b1;
    end
    if (!got) fail("ce_before_reset");
    #2 rst_n = 1'b0;
    #1;
    s = snap(0);
    chk("arst_ce", 32'(s.ce), 0);
    chk("arst_rd", 32'(s.rd), 0);
    chk("arst_wr", 32'(s.wr), 0);
    chk("arst_busy", 32'(s.busy), 0);
    chk("arst_rdata", 32'(s.rdata), 0);
    set_req(0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      s = snap(0);
      chk("arst_no_ack", 32'(s.ack), 0);
    end
    chk("arst_mem", 32'(mem[8'h11]), 32'h33);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Requester 1 drops req during ACCESS; ack still arrives, pointer moves to 0.
    @(posedge clk); #1;
    push(1, 1'b0, 8'h20, 8'h00, 8'h5C);
    set_req(0, 1, 1'b1, 1'b0, 8'h20, 8'h00);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge clk); #1;
      s = snap(0);
      if (s.ce) got = 1'b1;
    end
    if (!got) fail("ce_early_drop");
    chk("early_drop_gnt", 32'(s.gnt), 1);
    set_req(0, 1, 1'b0, 1'b0, 8'h00, 8'h00);
    observe(0, 1, lat, ce_cyc);
    @(posedge clk); #1;
    push(0, 1'b0, 8'h11, 8'h00, 8'h33);
    push(1, 1'b0, 8'h13, 8'h00, 8'h0A);
    set_req(0, 0, 1'b1, 1'b0, 8'h11, 8'h00);
    set_req(0, 1, 1'b1, 1'b0, 8'h13, 8'h00);
    observe(0, 2, lat, ce_cyc);
    bi0.req = '0;

    repeat (4) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
